// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding,
// default operand width and the full-subtractor borrow equation.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: diff = a - b - borrowIn.
module full_subtractor
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic diff,
    output logic borrowOut
);

    assign diff      = a ^ b ^ borrowIn;
    assign borrowOut = fs_borrow(a, b, borrowIn);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrowIn), LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the signed overflow output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] difference,
    output logic             borrowOut
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             w_d;
    logic             w_brw_next;
    logic             w_last;
    logic             w_accept;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    assign w_accept = (r_state == IDLE) && inValid;
    assign w_last   = (r_count == LAST);

    full_subtractor u_fs (
        .a        (r_a[0]),
        .b        (r_b[0]),
        .borrowIn (r_brw),
        .diff     (w_d),
        .borrowOut(w_brw_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (inValid)  w_next_state = BUSY;
            BUSY:    if (w_last)   w_next_state = DONE;
            DONE:    if (outReady) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operands shift right so the current bit is always at index 0; the
    // result fills from the MSB so it is aligned after exactly WIDTH shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_brw        <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else if (w_accept) begin
            r_count <= '0;
            r_a     <= a;
            r_b     <= b;
            r_brw   <= borrowIn;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
        end else if (r_state == BUSY) begin
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_brw  <= w_brw_next;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            if (w_last) begin
                r_borrow_out <= w_brw_next;
`ifdef SERIAL_SUB_OVF_EN
                r_ovf        <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign inReady    = (r_state == IDLE);
    assign outValid   = (r_state == DONE);
    assign difference = r_diff;
    assign borrowOut  = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); checks overflow when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrowIn;
    logic       outValid;
    logic       outReady;
    logic [7:0] difference;
    logic       borrowOut;
`ifdef SERIAL_SUB_OVF_EN
    logic       overflow;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   lat;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .a         (a),
        .b         (b),
        .borrowIn  (borrowIn),
        .outValid  (outValid),
        .outReady  (outReady),
        .difference(difference),
        .borrowOut (borrowOut)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept one operation; optionally queue its expected result.
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                         input logic push, input logic [7:0] ed, input logic ebo, input logic eov);
        int g;
        if (push) sb.push_back({ed, ebo, eov});
        g = 0;
        while (!inReady && g < 30) begin
            @(posedge clk); #1;
            g++;
        end
        a = ta; b = tb_; borrowIn = tbin; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!outValid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                          input logic [7:0] ed, input logic ebo, input logic eov);
        int n;
        issue(ta, tb_, tbin, 1'b1, ed, ebo, eov);
        wait_done(n);
        chk("latency", n, 8);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && outValid && outReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("difference", difference, mon_e.d);
                    chk("borrowOut", borrowOut, mon_e.bo);
`ifdef SERIAL_SUB_OVF_EN
                    chk("overflow", overflow, mon_e.ov);
`endif
                end
            end
        end
    end

    initial begin
        clk = 0; reset = 1; inValid = 0; a = 0; b = 0; borrowIn = 0; outReady = 1;
        #12;
        chk("rst_inReady", inReady, 1);
        chk("rst_outValid", outValid, 0);
        chk("rst_difference", difference, 0);
        chk("rst_borrowOut", borrowOut, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_overflow", overflow, 0);
`endif
        @(posedge clk); #1;
        reset = 0;

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Backpressure: result must hold and new requests must be ignored.
        outReady = 0;
        issue(8'hC3, 8'h41, 1'b0, 1'b1, 8'h82, 1'b0, 1'b0);
        wait_done(lat);
        chk("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_outValid", outValid, 1);
            chk("bp_difference", difference, 8'h82);
            chk("bp_borrowOut", borrowOut, 0);
            chk("bp_inReady", inReady, 0);
            a = 8'hFF; b = 8'h00; inValid = (i % 2 == 0);
            @(posedge clk); #1;
        end
        inValid = 0;
        outReady = 1;
        @(posedge clk); #1;
        chk("bp_idle_inReady", inReady, 1);
        chk("bp_idle_outValid", outValid, 0);

        // Abort in BUSY at count=3.
        issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1;
        #1;
        chk("abort_outValid", outValid, 0);
        chk("abort_difference", difference, 0);
        chk("abort_borrowOut", borrowOut, 0);
        chk("abort_inReady", inReady, 1);
        @(posedge clk); #1;
        reset = 0;
        run_op(8'h34, 8'h12, 1'b0, 8'h22, 1'b0, 1'b0);

        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
